// File: rtl/sub_32_serial_if.sv
// Operand/result handshake bundle for the serial lookahead subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface sub_32_serial_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             b_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, d, b_out, ovf
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, d, b_out, ovf
   );
endinterface

// File: rtl/sub_32_serial.sv
// Multi-cycle subtractor d = a - b - b_in, one SLICE_W-bit lookahead slice per clock.
// Computed as a + ~b + ~b_in; the running carry register links consecutive slices.
module sub_32_serial #(
   parameter int WIDTH   = 32,
   parameter int SLICE_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   sub_32_serial_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   d_r;
   logic               carry_r;
   logic               b_out_r;
   logic               ovf_r;
   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] d_sl;
   logic               c_out;
   logic               last;
   logic               in_ready_c;
   logic               out_valid_c;

   // Carries fully expanded: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0, no ripple.
   function automatic logic [SLICE_W:0] lookahead_slice(
      input logic [SLICE_W-1:0] x,
      input logic [SLICE_W-1:0] y_n,
      input logic               c0
   );
      logic [SLICE_W-1:0] p;
      logic [SLICE_W-1:0] g;
      logic [SLICE_W:0]   c;
      logic [SLICE_W-1:0] s;
      logic               pp;
      p    = x ^ y_n;
      g    = x & y_n;
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < SLICE_W; i++) begin
         pp = 1'b1;
         for (int k = 0; k <= i; k++) pp = pp & p[k];
         c[i+1] = pp & c0;
         for (int j = 0; j <= i; j++) begin
            pp = g[j];
            for (int k = j + 1; k <= i; k++) pp = pp & p[k];
            c[i+1] = c[i+1] | pp;
         end
      end
      s = p ^ c[SLICE_W-1:0];
      return {c[SLICE_W], s};
   endfunction

   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

   assign a_sl = a_r[int'(cnt) * SLICE_W +: SLICE_W];
   assign b_sl = b_r[int'(cnt) * SLICE_W +: SLICE_W];
   assign {c_out, d_sl} = lookahead_slice(a_sl, ~b_sl, carry_r);
   assign last = (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         d_r     <= '0;
         b_out_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  carry_r <= ~bus.b_in;
                  d_r     <= '0;
                  cnt     <= '0;
               end
            end
            RUN: begin
               d_r[int'(cnt) * SLICE_W +: SLICE_W] <= d_sl;
               carry_r <= c_out;
               cnt     <= cnt + 1'b1;
               // Final slice: borrow is the inverted carry, overflow from captured signs.
               if (last) begin
                  b_out_r <= ~c_out;
                  ovf_r   <= sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], d_sl[SLICE_W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.d         = d_r;
   assign bus.b_out     = b_out_r;
   assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_sub_32_serial.sv
// Directed and randomized checks of sub_32_serial against an arithmetic reference model.
module tb_sub_32_serial;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   sub_32_serial_if #(.WIDTH(32)) bus ();

   sub_32_serial #(.WIDTH(32), .SLICE_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned 33-bit difference gives d and borrow; overflow from operand/result signs.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        output logic [31:0] d, output logic bo, output logic ov);
      logic [32:0] diff;
      diff = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      d    = diff[31:0];
      bo   = diff[32];
      ov   = (a[31] != b[31]) && (d[31] != a[31]);
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input int stall, input bit toggle);
      logic [31:0] ed;
      logic        eb;
      logic        eo;
      int          lat;
      int          w;
      model(a, b, bin, ed, eb, eo);
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 20) begin step(); w++; end
      chk({tag, "_ready"}, bus.in_ready, 1'b1);
      bus.out_ready = (stall == 0);
      bus.a = a; bus.b = b; bus.b_in = bin; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         if (toggle) begin
            bus.a = $urandom; bus.b = $urandom; bus.b_in = 1'($urandom);
            bus.in_valid = 1'($urandom);
         end
         chk({tag, "_busy"}, bus.in_ready, 1'b0);
         step();
         lat++;
      end
      bus.in_valid = 1'b0;
      chk({tag, "_lat"}, lat, 8);
      chk({tag, "_d"}, bus.d, ed);
      chk({tag, "_bout"}, bus.b_out, eb);
      chk({tag, "_ovf"}, bus.ovf, eo);
      for (int i = 0; i < stall; i++) begin
         if (toggle) begin bus.a = $urandom; bus.b = $urandom; end
         step();
         chk({tag, "_hold_v"}, bus.out_valid, 1'b1);
         chk({tag, "_hold_d"}, bus.d, ed);
         chk({tag, "_hold_rdy"}, bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      step();
      chk({tag, "_cons_v"}, bus.out_valid, 1'b0);
      chk({tag, "_cons_rdy"}, bus.in_ready, 1'b1);
   endtask

   initial begin
      logic [31:0] ed1, ed2, ra, rb;
      logic        eb1, eo1, eb2, eo2, rbin;
      int          acc2, ov_at, ov1_at;
      logic [31:0] d1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b1;
      step(); step();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_d", bus.d, 32'd0);
      chk("rst_bout", bus.b_out, 1'b0);
      chk("rst_ovf", bus.ovf, 1'b0);
      rst = 1'b0;
      step();

      do_op("basic", 32'd5, 32'd3, 1'b0, 0, 1'b0);
      do_op("wrap", 32'd0, 32'd1, 1'b0, 0, 1'b0);
      do_op("eq_bin", 32'h12345678, 32'h12345678, 1'b1, 0, 1'b0);
      do_op("ovf_neg", 32'h80000000, 32'd1, 1'b0, 0, 1'b0);
      do_op("ovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
      do_op("bp", 32'hDEADBEEF, 32'h0000BEEF, 1'b0, 5, 1'b1);

      // Reset during the fourth RUN cycle discards the operation.
      bus.a = 32'hFFFF0000; bus.b = 32'h1; bus.b_in = 1'b0; bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_rdy", bus.in_ready, 1'b1);
      chk("mid_rst_v", bus.out_valid, 1'b0);
      chk("mid_rst_d", bus.d, 32'd0);
      do_op("post_rst", 32'd10, 32'd4, 1'b0, 0, 1'b0);

      // Back-to-back with in_valid and out_ready held high.
      model(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, ed1, eb1, eo1);
      model(32'h00000100, 32'h00000200, 1'b0, ed2, eb2, eo2);
      bus.a = 32'hCAFEF00D; bus.b = 32'h0BADBEEF; bus.b_in = 1'b1;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.a = 32'h00000100; bus.b = 32'h00000200; bus.b_in = 1'b0;
      acc2 = -1; ov_at = -1; ov1_at = -1; d1 = '0;
      for (int k = 1; k <= 18; k++) begin
         logic rdy_before;
         rdy_before = bus.in_ready;
         step();
         if (rdy_before && !bus.in_ready && acc2 < 0) begin
            acc2 = k;
            bus.in_valid = 1'b0;
         end
         if (bus.out_valid && ov1_at < 0) begin ov1_at = k; d1 = bus.d; end
         else if (bus.out_valid && ov1_at >= 0 && ov_at < 0 && k > ov1_at + 1) begin
            ov_at = k;
            chk("b2b_d2", bus.d, ed2);
            chk("b2b_bout2", bus.b_out, eb2);
         end
      end
      bus.in_valid = 1'b0;
      chk("b2b_out1_at", ov1_at, 8);
      chk("b2b_d1", d1, ed1);
      chk("b2b_accept2_at", acc2, 10);
      chk("b2b_out2_at", ov_at, 18);
      step();

      for (int r = 0; r < 12; r++) begin
         ra = $urandom; rb = $urandom; rbin = 1'($urandom);
         if (r == 0) rb = ra;
         if (r == 1) begin ra = 32'd0; rb = 32'hFFFFFFFF; end
         do_op("rand", ra, rb, rbin, int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
